// File: rtl/wb_mem_arbiter.sv
// Arbitrates SerV ibus/dbus onto one Wishbone memory port, with a one-word fetch buffer.
// Hit: ack 1 cycle after request; miss: mem_cyc next cycle, ack 1 cycle after mem_ack; requests wait until served.
module wb_mem_arbiter #(
    parameter int ADR_W   = 14,
    parameter bit IBUF_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      ibus_adr,
    input  logic             ibus_cyc,
    output logic [31:0]      ibus_rdt,
    output logic             ibus_ack,
    input  logic [31:0]      dbus_adr,
    input  logic [31:0]      dbus_dat,
    input  logic [3:0]       dbus_sel,
    input  logic             dbus_we,
    input  logic             dbus_cyc,
    output logic [31:0]      dbus_rdt,
    output logic             dbus_ack,
    output logic             mem_cyc,
    output logic [ADR_W-1:0] mem_adr,
    output logic             mem_we,
    output logic [31:0]      mem_dat,
    output logic [3:0]       mem_sel,
    input  logic [31:0]      mem_rdt,
    input  logic             mem_ack
);

    typedef enum logic [2:0] {
        IDLE,
        MEM_I,
        MEM_D,
        RESP_I,
        RESP_D
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ADR_W-1:0] ibus_word;
    logic [ADR_W-1:0] dbus_word;
    logic             buf_vld;
    logic [ADR_W-1:0] buf_tag;
    logic [31:0]      buf_dat;
    logic             buf_hit;
    logic             unused_adr_bits;

    assign ibus_word = ibus_adr[ADR_W+1:2];
    assign dbus_word = dbus_adr[ADR_W+1:2];
    // High bits alias and byte offset is carried by sel, so both are dropped.
    assign unused_adr_bits = ^{ibus_adr[31:ADR_W+2], ibus_adr[1:0],
                               dbus_adr[31:ADR_W+2], dbus_adr[1:0]};

    assign buf_hit = IBUF_EN && buf_vld && (buf_tag == ibus_word);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ibus_ack  = 1'b0;
        dbus_ack  = 1'b0;
        case (state)
            IDLE: begin
                if (dbus_cyc) begin
                    state_nxt = MEM_D;
                end else if (ibus_cyc) begin
                    state_nxt = buf_hit ? RESP_I : MEM_I;
                end
            end
            MEM_I: begin
                if (mem_ack) begin
                    state_nxt = RESP_I;
                end
            end
            MEM_D: begin
                if (mem_ack) begin
                    state_nxt = RESP_D;
                end
            end
            RESP_I: begin
                ibus_ack  = 1'b1;
                state_nxt = IDLE;
            end
            RESP_D: begin
                dbus_ack  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_cyc  <= 1'b0;
            mem_adr  <= '0;
            mem_we   <= 1'b0;
            mem_dat  <= '0;
            mem_sel  <= '0;
            ibus_rdt <= '0;
            dbus_rdt <= '0;
            buf_vld  <= 1'b0;
            buf_tag  <= '0;
            buf_dat  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dbus_cyc) begin
                        mem_cyc <= 1'b1;
                        mem_adr <= dbus_word;
                        mem_we  <= dbus_we;
                        mem_dat <= dbus_dat;
                        mem_sel <= dbus_sel;
                        // A store to the buffered word would leave a stale fetch behind.
                        if (dbus_we && (buf_tag == dbus_word)) begin
                            buf_vld <= 1'b0;
                        end
                    end else if (ibus_cyc) begin
                        if (buf_hit) begin
                            ibus_rdt <= buf_dat;
                        end else begin
                            mem_cyc <= 1'b1;
                            mem_adr <= ibus_word;
                            mem_we  <= 1'b0;
                            mem_dat <= '0;
                            mem_sel <= 4'hF;
                        end
                    end
                end
                MEM_I: begin
                    if (mem_ack) begin
                        mem_cyc  <= 1'b0;
                        ibus_rdt <= mem_rdt;
                        buf_tag  <= mem_adr;
                        buf_dat  <= mem_rdt;
                        buf_vld  <= 1'b1;
                    end
                end
                MEM_D: begin
                    if (mem_ack) begin
                        mem_cyc  <= 1'b0;
                        dbus_rdt <= mem_rdt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
